// File: rtl/enigma_pkg.sv
// Shared constants, FSM state encoding and mod-26 helpers for the Enigma step controller.
// Combinational helpers only; no timing or backpressure of its own.
package enigma_pkg;

  localparam int ALPHA = 26;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_PASS,
    ST_DONE
  } state_t;

  // Operands are always 0..25, so one conditional correction is enough.
  function automatic logic [IDX_W-1:0] mod26_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDX_W+1)'(ALPHA)) s = s - (IDX_W+1)'(ALPHA);
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] mod26_sub(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (s[IDX_W]) s = s + (IDX_W+1)'(ALPHA);
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rotor_counter.sv
// Mod-26 rotor position counter with load, step enable and notch-match flag.
// Position updates one cycle after step/load; no handshake, the parent gates step.
module rotor_counter
  import enigma_pkg::*;
#(
  parameter logic [IDX_W-1:0] NOTCH = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             step,
  output logic [IDX_W-1:0] pos,
  output logic             at_notch
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
    end else if (load) begin
      pos <= load_val;
    end else if (step) begin
      pos <= mod26_add(pos, IDX_W'(1));
    end
  end

  // Compared against the pre-step position, which is what drives the carry.
  assign at_notch = (pos == NOTCH);

endmodule

// File: rtl/enigma_step_ctrl.sv
// Enigma sequencer: steps rotors, then time-shares one lookup across passes; ENIGMA_DOUBLE_STEP_EN adds the double-step anomaly.
// Latency: accept -> out_valid after NUM_ROTORS+2 cycles; one char per NUM_ROTORS+3 cycles.
// Backpressure: out_ready low holds DONE indefinitely; in_ready stays low until the output is taken.
module enigma_step_ctrl
  import enigma_pkg::*;
#(
  parameter int                        NUM_ROTORS = 3,
  parameter logic [5*NUM_ROTORS-1:0]   NOTCH_VEC  = {5'd21, 5'd4, 5'd16}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IDX_W-1:0]             in_idx,
  input  logic                         load,
  input  logic [IDX_W*NUM_ROTORS-1:0]  load_pos,
  output logic [31:0]                  lut_sel,
  output logic [1:0]                   lut_rotor,
  input  logic [7:0]                   lut_res,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_idx,
  output logic [IDX_W*NUM_ROTORS-1:0]  pos,
  output logic                         busy,
  output logic                         err
);

  state_t           state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0]      rpos [NUM_ROTORS];
  logic [NUM_ROTORS-1:0] at_notch;
  logic [NUM_ROTORS-1:0] step_en;
  logic                  load_en;
  logic [IDX_W-1:0]      cur_pos;
  logic [IDX_W-1:0]      res_idx;
  logic                  unused_notch;

  assign load_en = (state_q == ST_IDLE) && load;

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_rotor
    rotor_counter #(
      .NOTCH (NOTCH_VEC[g*IDX_W +: IDX_W])
    ) u_rotor (
      .clk      (clk),
      .rst      (rst),
      .load     (load_en),
      .load_val (load_pos[g*IDX_W +: IDX_W]),
      .step     (step_en[g]),
      .pos      (rpos[g]),
      .at_notch (at_notch[g])
    );
    assign pos[g*IDX_W +: IDX_W] = rpos[g];
  end

  // The last rotor has nothing to carry into.
  assign unused_notch = at_notch[NUM_ROTORS-1];

  always_comb begin
    step_en = '0;
    if (state_q == ST_STEP) begin
      step_en[0] = 1'b1;
      for (int i = 1; i < NUM_ROTORS; i++) begin
        step_en[i] = step_en[i-1] & at_notch[i-1];
      end
`ifdef ENIGMA_DOUBLE_STEP_EN
      // Middle rotor sitting on its notch steps itself and the left rotor.
      if (at_notch[1]) begin
        step_en[1] = 1'b1;
        step_en[2] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (k_q == 2'(i)) cur_pos = rpos[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cur_d     = cur_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    lut_sel   = '0;
    lut_rotor = '0;
    res_idx   = '0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        in_ready = !load;
        if (in_valid && !load) begin
          if (in_idx >= IDX_W'(ALPHA)) begin
            err_d = 1'b1;
            cur_d = '0;
          end else begin
            cur_d = in_idx;
          end
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        k_d     = '0;
        state_d = ST_PASS;
      end
      ST_PASS: begin
        lut_sel   = 32'(mod26_add(cur_q, cur_pos));
        lut_rotor = k_q;
        if (lut_res >= 8'(ALPHA)) begin
          err_d   = 1'b1;
          res_idx = '0;
        end else begin
          res_idx = lut_res[IDX_W-1:0];
        end
        cur_d = mod26_sub(res_idx, cur_pos);
        if (k_q == 2'(NUM_ROTORS-1)) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_idx   = cur_q;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Self-checking bench for enigma_step_ctrl with a behavioural lookup and an output scoreboard.
module tb_enigma_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic        load;
  logic [14:0] load_pos;
  logic [31:0] lut_sel;
  logic [1:0]  lut_rotor;
  logic [7:0]  lut_res;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [14:0] pos;
  logic        busy;
  logic        err;

  int          lut_mode;
  int          n_checks = 0;
  int          n_err = 0;
  logic [4:0]  exp_q [$];

  always #5 clk = ~clk;

  enigma_step_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .load      (load),
    .load_pos  (load_pos),
    .lut_sel   (lut_sel),
    .lut_rotor (lut_rotor),
    .lut_res   (lut_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pos       (pos),
    .busy      (busy),
    .err       (err)
  );

  // 0: identity, 1: shift by one, other: out-of-range result
  always_comb begin
    case (lut_mode)
      0:       lut_res = lut_sel[7:0];
      1:       lut_res = (lut_sel[7:0] == 8'd25) ? 8'd0 : lut_sel[7:0] + 8'd1;
      default: lut_res = 8'd200;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: compare on every completed output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_output", 32'(out_idx), 32'hFFFF);
        else check_val("out_idx", 32'(out_idx), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [14:0] v);
    load = 1'b1;
    load_pos = v;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) check_val("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send(input logic [4:0] idx, input logic [4:0] exp);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_idx = idx;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_idx = '0;
    load = 1'b0;
    load_pos = '0;
    out_ready = 1'b1;
    lut_mode = 0;
    repeat (3) tick();
    rst = 1'b0;

    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_pos", 32'(pos), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_lut_sel", lut_sel, 32'd0);

    // Identity lookup with latency and per-pass select checks
    do_load({5'd3, 5'd7, 5'd11});
    in_valid = 1'b1;
    in_idx = 5'd4;
    exp_q.push_back(5'd4);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      if (n == 1) check_val("step_in_ready", 32'(in_ready), 32'd0);
      if (n == 2) begin
        check_val("pass0_sel", lut_sel, 32'd16);
        check_val("pass0_rotor", 32'(lut_rotor), 32'd0);
        check_val("pos_after_step", 32'(pos), 32'({5'd3, 5'd7, 5'd12}));
      end
      if (n == 3) begin
        check_val("pass1_sel", lut_sel, 32'd11);
        check_val("pass1_rotor", 32'(lut_rotor), 32'd1);
      end
      tick();
      n++;
    end
    check_val("out_valid_cycle", 32'(n), 32'd5);
    wait_idle();

    // Shift-by-one lookup adds one per pass
    lut_mode = 1;
    send(5'd0, 5'd3);
    send(5'd25, 5'd2);
    wait_idle();
    check_val("shift_err", 32'(err), 32'd0);
    lut_mode = 0;

    // Notch carry and plain wrap
    do_load({5'd0, 5'd0, 5'd16});
    send(5'd5, 5'd5);
    wait_idle();
    check_val("notch_carry_pos", 32'(pos), 32'({5'd0, 5'd1, 5'd17}));
    do_load({5'd0, 5'd0, 5'd25});
    send(5'd6, 5'd6);
    wait_idle();
    check_val("wrap_pos", 32'(pos), 32'd0);

    // Middle rotor on its notch
    do_load({5'd0, 5'd4, 5'd10});
    send(5'd8, 5'd8);
    wait_idle();
`ifdef ENIGMA_DOUBLE_STEP_EN
    check_val("double_step_pos", 32'(pos), 32'({5'd1, 5'd5, 5'd11}));
`else
    check_val("double_step_pos", 32'(pos), 32'({5'd0, 5'd4, 5'd11}));
`endif

    // Output backpressure
    out_ready = 1'b0;
    send(5'd7, 5'd7);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
      check_val("hold_out_idx", 32'(out_idx), 32'd7);
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    wait_idle();

    // Load takes priority over a simultaneous letter
    load = 1'b1;
    load_pos = {5'd2, 5'd9, 5'd13};
    in_valid = 1'b1;
    in_idx = 5'd3;
    #1;
    check_val("load_in_ready", 32'(in_ready), 32'd0);
    tick();
    load = 1'b0;
    in_valid = 1'b0;
    check_val("load_busy", 32'(busy), 32'd0);
    check_val("load_pos", 32'(pos), 32'({5'd2, 5'd9, 5'd13}));

    // Out-of-range letter treated as 0
    send(5'd30, 5'd0);
    wait_idle();
    check_val("in_range_err", 32'(err), 32'd1);

    // Reset in the middle of a pass
    in_valid = 1'b1;
    in_idx = 5'd5;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("mid_pass_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_pos", 32'(pos), 32'd0);
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_err", 32'(err), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);

    // Out-of-range lookup result: pass 0 gives 0-1 = 25, later passes 0
    lut_mode = 2;
    send(5'd11, 5'd0);
    wait_idle();
    check_val("lut_range_err", 32'(err), 32'd1);
    lut_mode = 0;

    repeat (2) tick();
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/enigma_step_ctrl.md
# enigma_step_ctrl

Sequencer for the Enigma datapath: accepts one letter index at a time, steps the rotor positions odometer-style, then time-shares a single external 26-entry substitution lookup (8-bit entries, 32-bit select) across all rotor passes. Each pass offsets the select by the rotor position, indexes the shared lookup and removes the offset from the result. Sits between the keyboard/UART front end and the lookup table. Owns the rotor position state and the read scheduling of the shared table.

## Interface
- NUM_ROTORS, 3, number of rotor passes per character (1..3)
- NOTCH_VEC, {5'd21,5'd4,5'd16}, packed 5-bit notch position per rotor; rotor 0 in the LSBs
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1 / 1  input letter handshake
- in_idx  in  5  letter index, valid range 0..25
- load  in  1  load rotor start positions; acted on in IDLE only
- load_pos  in  5*NUM_ROTORS  packed start positions; rotor 0 in the LSBs
- lut_sel  out  32  select to the shared lookup, 0..25
- lut_rotor  out  2  which rotor's table is addressed
- lut_res  in  8  lookup result; combinational, same cycle as lut_sel
- out_valid / out_ready  out / in  1 / 1  output letter handshake
- out_idx  out  5  encoded letter index
- pos  out  5*NUM_ROTORS  current rotor positions
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky range-error flag; cleared only by rst

## Operation
- FSM states: IDLE, STEP, PASS, DONE. A pass counter k runs from 0 to NUM_ROTORS-1.
- **IDLE:**
  - in_ready = !load.
  - load = 1: pos <= load_pos. Any in_valid in the same cycle is not accepted.
  - in_valid & in_ready: capture in_idx, go to STEP.
- **STEP (1 cycle):**
  - pos[0] <= pos[0]+1 mod 26.
  - pos[i+1] steps when pos[i] equals NOTCH[i] before the step (odometer carry).
  - Go to PASS with k=0 and cur = captured letter.
- **PASS (1 cycle per rotor):**
  - lut_sel = (cur + pos[k]) mod 26, zero-extended to 32 bits; lut_rotor = k.
  - cur <= (lut_res[4:0] - pos[k]) mod 26.
  - After k = NUM_ROTORS-1, go to DONE.
- **DONE:**
  - out_valid = 1 and out_idx = cur, both held stable until out_ready.
  - out_valid & out_ready: go to IDLE.
- **Arithmetic:**
  - 6-bit intermediate sums.
  - Add: subtract 26 when the sum is >= 26.
  - Subtract: add 26 when the result is negative.
- **Range errors:**
  - in_idx >= 26: err <= 1; the letter is treated as 0.
  - lut_res >= 26 during PASS: err <= 1; the result is treated as 0.
- **Position wrap:** 25 -> 0. Wrap alone never carries; only the notch match carries.
- **Outside PASS:** lut_sel = 0 and lut_rotor = 0.
- **rst (any state, including mid-character):** in-flight character is discarded.
  - State = IDLE; all pos = 0; cur = 0.
  - out_valid = 0, out_idx = 0, err = 0, busy = 0, in_ready = 1.

## Timing
- Acceptance at cycle 0 -> STEP at cycle 1 -> PASS at cycles 2..NUM_ROTORS+1 -> out_valid at cycle NUM_ROTORS+2 (cycle 5 for 3 rotors).
- With out_ready held high, one character completes every NUM_ROTORS+3 cycles.
- in_ready is low from the acceptance edge until DONE completes.
- pos updates are visible from cycle 2.
- Backpressure on out_ready holds the FSM in DONE without limit; no data loss.

## Configuration
- **ENIGMA_DOUBLE_STEP_EN defined:** historical double-step anomaly. In STEP, if pos[1] == NOTCH[1] before the step, pos[1] also steps, and so does pos[2], even without a carry from rotor 0. Requires NUM_ROTORS == 3.
- **Not defined:** pure odometer stepping only.

## Structure
- **enigma_pkg:**
  - ALPHA = 26, IDX_W = 5.
  - FSM state enum.
  - mod26_add / mod26_sub functions.
- **rotor_counter:** one natural sub-module, instantiated NUM_ROTORS times.
  - Mod-26 counter with load, step enable and notch-match output.
  - The carry chain is wired in the parent.

## Test plan
- **Identity LUT** (lut_res = lut_sel): load pos {3,7,11}; send in_idx 4 -> out_idx 4, out_valid at cycle 5, pos[0] = 12.
- **Shift-by-1 LUT:** send 0, then 25 -> out_idx 3, then 2; err stays 0.
- **Notch carry:** load pos {0,0,16}; send one letter -> pos {0,1,17}.
  - Load pos {0,0,25}; send -> pos {0,0,0} (wrap, no carry).
- **Double step:** load pos {0,4,10}; send -> EN: {1,5,11}; not defined: {0,4,11}.
- **Handshake:** hold out_ready low 4 cycles in DONE -> out_valid and out_idx stable, in_ready 0.
  - Load together with in_valid in IDLE -> no acceptance, pos = load_pos.
- **Errors/reset:** in_idx 30 -> err 1.
  - rst asserted during PASS -> next cycle IDLE, pos all 0, out_valid 0, err 0.
